// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM states and the default datapath width.
package muldiv_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } state_e;

endpackage

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negate. It yields the magnitude of an operand
// when i_neg is its sign bit, and restores the sign of a result otherwise.
module muldiv_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_val,
  input  logic         i_neg,
  output logic [W-1:0] o_val
);

  assign o_val = i_neg ? (~i_val + W'(1)) : i_val;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding the architectural HI/LO pair.
// The magnitudes are processed one bit per cycle, and the signs are applied in FIX.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e             r_state;
  op_e                r_op;
  logic [CW-1:0]      r_cnt;
  logic               r_busy;
  logic               r_done;
  logic               r_div_zero;
  logic               r_dz;
  logic               r_neg_a;
  logic               r_neg_b;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   r_opa;
  logic [WIDTH-1:0]   r_m;
  logic [2*WIDTH-1:0] r_prod;

  logic               w_in_signed;
  logic               w_in_div;
  logic               w_is_div;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [WIDTH:0]     w_div_shift;
  logic [WIDTH:0]     w_div_diff;
  logic [2*WIDTH-1:0] w_div_next;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;

  assign w_in_signed = (op == OP_MULT) || (op == OP_DIV);
  assign w_in_div    = (op == OP_DIV)  || (op == OP_DIVU);
  assign w_is_div    = (r_op == OP_DIV) || (r_op == OP_DIVU);

  muldiv_sign_fix #(.W(WIDTH)) u_abs_a (
    .i_val (opA),
    .i_neg (w_in_signed & opA[WIDTH-1]),
    .o_val (w_abs_a)
  );

  muldiv_sign_fix #(.W(WIDTH)) u_abs_b (
    .i_val (opB),
    .i_neg (w_in_signed & opB[WIDTH-1]),
    .o_val (w_abs_b)
  );

  // Multiply step: the upper half accumulates r_m, and the multiplier shifts out of the low half
  assign w_mul_sum  = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_m} : '0);
  assign w_mul_next = {w_mul_sum, r_prod[WIDTH-1:1]};

  // Restoring divide step: {rem, quotient/dividend} shifts left, and the quotient bit enters at bit 0
  assign w_div_shift = {r_prod[2*WIDTH-1:WIDTH], r_prod[WIDTH-1]};
  assign w_div_diff  = w_div_shift - {1'b0, r_m};
  assign w_div_next  = w_div_diff[WIDTH]
                     ? {w_div_shift[WIDTH-1:0], r_prod[WIDTH-2:0], 1'b0}
                     : {w_div_diff[WIDTH-1:0],  r_prod[WIDTH-2:0], 1'b1};

  muldiv_sign_fix #(.W(2*WIDTH)) u_fix_prod (
    .i_val (r_prod),
    .i_neg (r_neg_a ^ r_neg_b),
    .o_val (w_prod_fix)
  );

  muldiv_sign_fix #(.W(WIDTH)) u_fix_quo (
    .i_val (r_prod[WIDTH-1:0]),
    .i_neg (r_neg_a ^ r_neg_b),
    .o_val (w_quo_fix)
  );

  // The remainder follows the dividend's sign
  muldiv_sign_fix #(.W(WIDTH)) u_fix_rem (
    .i_val (r_prod[2*WIDTH-1:WIDTH]),
    .i_neg (r_neg_a),
    .o_val (w_rem_fix)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (hi_we) r_hi <= wdata;
          if (lo_we) r_lo <= wdata;
          if (start) begin
            r_op       <= op_e'(op);
            r_neg_a    <= w_in_signed & opA[WIDTH-1];
            r_neg_b    <= w_in_signed & opB[WIDTH-1];
            r_dz       <= w_in_div && (opB == '0);
            r_opa      <= opA;
            r_m        <= w_in_div ? w_abs_b : w_abs_a;
            r_prod     <= {{WIDTH{1'b0}}, (w_in_div ? w_abs_a : w_abs_b)};
            r_cnt      <= '0;
            r_div_zero <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= RUN;
          end
        end
        RUN: begin
          r_prod <= w_is_div ? w_div_next : w_mul_next;
          if (r_cnt == CW'(WIDTH-1)) begin
            r_cnt   <= '0;
            r_state <= FIX;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        FIX: begin
          if (w_is_div) begin
            if (r_dz) begin
              r_lo       <= '1;
              r_hi       <= r_opa;
              r_div_zero <= 1'b1;
            end else begin
              r_lo <= w_quo_fix;
              r_hi <= w_rem_fix;
            end
          end else begin
            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
            r_lo <= w_prod_fix[WIDTH-1:0];
          end
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign div_zero = r_div_zero;
  assign hi       = r_hi;
  assign lo       = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: each accepted operation pushes its expected HI/LO,
// div_zero and completion cycle, and a monitor checks them whenever done pulses.
module tb_muldiv_unit;

  localparam int W   = 32;
  localparam int LAT = W + 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] opA, opB;
  logic         hi_we, lo_we;
  logic [W-1:0] wdata;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  logic prev_done = 1'b0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .opA(opA), .opB(opB),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Reference: plain integer arithmetic on the architectural definitions
  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   e;
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    e.dz  = 1'b0;
    e.cyc = 0;
    case (o)
      2'b00: begin p = sa * sb; e.hi = p[63:32]; e.lo = p[31:0]; end
      2'b01: begin p = {32'b0, a} * {32'b0, b}; e.hi = p[63:32]; e.lo = p[31:0]; end
      default: begin
        if (b == 0) begin
          e.lo = '1; e.hi = a; e.dz = 1'b1;
        end else if (o == 2'b11) begin
          e.lo = a / b; e.hi = a % b;
        end else begin
          q = sa / sb; r = sa % sb;
          e.lo = q[31:0]; e.hi = r[31:0];
        end
      end
    endcase
    return e;
  endfunction

  // Drive a start at the current negedge and enqueue its expectation
  task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e = model(o, a, b);
    e.cyc = cyc + 1;
    exp_q.push_back(e);
    start = 1'b1; op = o; opA = a; opB = b;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (busy && n < 200) begin n++; @(negedge clk); end
    if (busy) chk({nm, "_timeout"}, 64'(busy), 64'd0);
  endtask

  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    int bc;
    @(negedge clk);
    issue(o, a, b);
    @(negedge clk);
    start = 1'b0;
    bc = 0;
    while (busy && bc < 200) begin bc++; @(negedge clk); end
    chk("busy_len", 64'(bc), 64'(LAT));
  endtask

  function automatic logic [W-1:0] rand_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h0000_0001;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 50));
      default: return 32'($urandom);
    endcase
  endfunction

  // Monitor: compare against the scoreboard whenever done is presented
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      if (exp_q.size() == 0) begin
        chk("spurious_done", 64'(done), 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("hi", 64'(hi), 64'(e.hi));
        chk("lo", 64'(lo), 64'(e.lo));
        chk("div_zero", 64'(div_zero), 64'(e.dz));
        chk("latency", 64'(cyc - e.cyc), 64'(LAT));
      end
      if (prev_done) chk("done_width", 64'(prev_done), 64'd0);
    end
    prev_done = done;
  end

  initial begin
    int dcount;
    logic [1:0] ro;
    rst = 1'b1; start = 1'b0; op = 2'b00; opA = '0; opB = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_dz", 64'(div_zero), 64'd0);
    rst = 1'b0;

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(2'b00, 32'hFFFF_FFFD, 32'd7);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2);
    run_op(2'b11, 32'd100, 32'd7);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(2'b11, 32'h0000_1234, 32'd0);
    chk("dz_sticky", 64'(div_zero), 64'd1);

    // div_zero clears on the next accepted start
    @(negedge clk);
    issue(2'b01, 32'd2, 32'd3);
    @(negedge clk);
    start = 1'b0;
    chk("dz_clear", 64'(div_zero), 64'd0);
    wait_idle("mul23");

    // Reset in the middle of RUN aborts with no done pulse
    @(negedge clk);
    start = 1'b1; op = 2'b01; opA = 32'd1234; opB = 32'd5678;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_hi", 64'(hi), 64'd0);
    chk("abort_lo", 64'(lo), 64'd0);
    dcount = 0;
    repeat (40) begin @(negedge clk); if (done) dcount++; end
    chk("abort_no_done", 64'(dcount), 64'd0);
    run_op(2'b00, 32'hFFFF_FFFF, 32'h8000_0000);

    // MTHI/MTLO in IDLE
    @(negedge clk);
    hi_we = 1'b1; wdata = 32'hA5A5_A5A5;
    @(negedge clk);
    hi_we = 1'b0;
    chk("mthi", 64'(hi), 64'hA5A5_A5A5);
    lo_we = 1'b1; hi_we = 1'b1; wdata = 32'h5A5A_0001;
    @(negedge clk);
    lo_we = 1'b0; hi_we = 1'b0;
    chk("mtlo_both_lo", 64'(lo), 64'h5A5A_0001);
    chk("mtlo_both_hi", 64'(hi), 64'h5A5A_0001);

    // Writes while busy are dropped; a second start mid-RUN is ignored
    wdata = 32'hA5A5_A5A5; hi_we = 1'b1;
    @(negedge clk);
    hi_we = 1'b0;
    issue(2'b01, 32'd5, 32'd6);
    @(negedge clk);
    start = 1'b0;
    hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    hi_we = 1'b0;
    chk("hi_we_busy", 64'(hi), 64'hA5A5_A5A5);
    repeat (10) @(negedge clk);
    start = 1'b1; op = 2'b11; opA = 32'd9; opB = 32'd1;
    @(negedge clk);
    start = 1'b0;
    wait_idle("ignored_start");

    // start together with MTLO: write lands now, the result overwrites it later
    @(negedge clk);
    issue(2'b01, 32'd3, 32'd4);
    lo_we = 1'b1; wdata = 32'h0000_0011;
    @(negedge clk);
    start = 1'b0; lo_we = 1'b0;
    chk("start_mtlo", 64'(lo), 64'h0000_0011);
    wait_idle("start_mtlo");

    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      run_op(ro, rand_operand(), rand_operand());
    end

    repeat (3) @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit downstream of the register file. Consumes its two read operands (regA, regB) for MULT/MULTU/DIV/DIVU.
- Holds the architectural HI/LO registers, which are read back for MFHI/MFLO.
- Multi-cycle, with a start/busy/done handshake. The control path stalls the core while busy=1.

Parameters:
WIDTH, 32, operand/result width; iteration count equals WIDTH

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  launch operation; sampled only in IDLE
op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start
opA  input  WIDTH  multiplicand / dividend (from regfile regA)
opB  input  WIDTH  multiplier / divisor (from regfile regB)
hi_we  input  1  MTHI write strobe
lo_we  input  1  MTLO write strobe
wdata  input  WIDTH  data for MTHI/MTLO
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse when HI/LO are updated
div_zero  output  1  sticky flag; set by a divide with opB==0, cleared by the next accepted start
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE; hi=lo=0; busy=done=div_zero=0; counter=0.
  - Reset mid-operation aborts the operation; no partial result is written.
- States are IDLE, RUN, FIX.
- IDLE, start=1 on edge k:
  - Latch op.
  - For signed ops, latch |opA| and |opB| and record the sign bits.
  - Clear accumulators and div_zero; go to RUN. busy=1 from edge k.
- RUN: one shift-add (multiply) or one restoring shift-subtract (divide) step per cycle, WIDTH cycles, counter 0..WIDTH-1, then go to FIX.
- FIX, one cycle, then IDLE:
  - Apply sign correction.
  - Write hi/lo.
  - done=1 for exactly that following cycle.
  - busy=0 from the same edge.
- Latency: start sampled at edge k gives new hi/lo and done=1 after edge k+WIDTH+1, which is 33 cycles for WIDTH=32.
- Multiply: {hi,lo} = 2*WIDTH-bit product. MULT negates the product when the operand signs differ.
- Divide:
  - lo=quotient, hi=remainder.
  - Signed: quotient negated when signs differ; remainder takes the dividend's sign.
  - 0x80000000 / -1 gives lo=0x80000000, hi=0.
- Divide by zero (opB==0):
  - Still takes the full latency.
  - lo=all ones, hi=opA (unmodified dividend), div_zero=1.
- start while busy: ignored, with no queuing.
- hi_we/lo_we in IDLE: write wdata on that edge. Both may be asserted at once.
- hi_we/lo_we while busy: dropped.
- start together with hi_we/lo_we in IDLE: the MTHI/MTLO write takes effect, and the operation result later overwrites it.
- hi/lo hold their value at all other times. Reads are combinational from the registers.

Decomposition:
- Shared package muldiv_pkg:
  - op encodings: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU.
  - state enum: IDLE, RUN, FIX.
  - WIDTH default constant.
- One natural sub-module: muldiv_sign_fix, a combinational abs/negate helper. It is used at operand capture and at result correction.
- Iteration datapath and FSM stay in muldiv_unit.

Test Plan:
- MULTU opA=0xFFFFFFFF, opB=0xFFFFFFFF -> after 33 cycles done=1 for one cycle; hi=0xFFFFFFFE, lo=0x00000001; busy high for exactly 33 cycles.
- MULT opA=-3 (0xFFFFFFFD), opB=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV opA=-7, opB=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIVU opA=100, opB=7 -> lo=14, hi=2.
- DIVU opA=0x1234, opB=0 -> lo=0xFFFFFFFF, hi=0x1234, div_zero=1. A following MULTU 2*3 clears div_zero at its start edge; result hi=0, lo=6.
- Assert rst at RUN cycle 10 of a MULTU -> next cycle busy=0, done=0, hi=lo=0. No done pulse ever appears. A subsequent start runs normally.
- MTHI wdata=0xA5A5A5A5 in IDLE -> hi=0xA5A5A5A5 next cycle. hi_we during busy -> hi unchanged. start pulsed again mid-RUN -> ignored, and the original result completes on schedule.
